// File: rtl/clk_div_pkg.sv
// Shared widths and the per-channel divider state record.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned NUM_CH_DEF = 2;
  // Channel state is held at the widest supported ratio; narrower
  // configurations simply keep the upper bits at zero.
  localparam int unsigned CNT_W_MAX  = 16;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef struct packed {
    cnt_t r;        // active ratio
    cnt_t c;        // position within the current period
    cnt_t p;        // pending ratio
    logic pending;  // p accepted but not yet applied
  } ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, glitch-free ratio hand-over and output decode.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             pending,
  output logic             div_out,
  output logic             div_tick
);

  ch_state_t st;
  ch_state_t st_nxt;
  logic      running;
  logic      wrap;

  // Channel state register
  always_ff @(posedge clk) begin
    if (reset) begin
      st.r       <= cnt_t'(RESET_DIV);
      st.c       <= '0;
      st.p       <= '0;
      st.pending <= 1'b0;
    end else begin
      st <= st_nxt;
    end
  end

  // Next state: count, capture new ratio, swap ratio at a period boundary
  always_comb begin
    st_nxt  = st;
    running = (st.r != '0);
    wrap    = enable && running && (st.c == st.r - cnt_t'(1));

    if (!running) begin
      st_nxt.c = '0;
    end else if (enable) begin
      st_nxt.c = wrap ? '0 : st.c + cnt_t'(1);
    end

    // A waiting ratio only takes over at a wrap so no period is truncated;
    // a disabled channel has no period to protect and switches at once.
    if (st.pending && (wrap || !running)) begin
      st_nxt.r       = st.p;
      st_nxt.c       = '0;
      st_nxt.pending = 1'b0;
    end

    // The top only asserts cfg_wr while nothing is pending, so this never
    // collides with the hand-over above.
    if (cfg_wr) begin
      st_nxt.p       = cnt_t'(cfg_div);
      st_nxt.pending = 1'b1;
    end
  end

  // Output decode straight from state: high for ceil(R/2), low for floor(R/2)
  always_comb begin
    pending  = st.pending;
    div_tick = wrap;
    div_out  = running && (st.c < (st.r - (st.r >> 1)));
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel ratio update port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]                                 cfg_div,
  output logic [NUM_CH-1:0]                                cfg_pending,
  output logic [NUM_CH-1:0]                                div_out,
  output logic [NUM_CH-1:0]                                div_tick
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] cfg_wr;

  // Ready unless the addressed channel still holds an unapplied ratio;
  // out-of-range channels are always ready so their writes drain away.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if ((cfg_ch == CH_W'(i)) && cfg_pending[i]) cfg_ready = 1'b0;
    end
  end

  // Route an accepted update to exactly one in-range channel
  always_comb begin
    cfg_wr = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cfg_wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    clk_div_ch #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .cfg_wr   (cfg_wr[g]),
      .cfg_div  (cfg_div),
      .pending  (cfg_pending[g]),
      .div_out  (div_out[g]),
      .div_tick (div_tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: period-level reference model, queued expectations.
module tb_clk_div_multi;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned RESET_DIV = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_ch;
  logic [CNT_W-1:0]    cfg_div;
  logic [NUM_CH-1:0]   cfg_pending;
  logic [NUM_CH-1:0]   div_out;
  logic [NUM_CH-1:0]   div_tick;

  clk_div_multi #(
    .CNT_W     (CNT_W),
    .NUM_CH    (NUM_CH),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_pending (cfg_pending),
    .div_out     (div_out),
    .div_tick    (div_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
    logic              ready;
    string             tag;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  // Reference model: per channel, the ratio of the running period, how many
  // enabled cycles of that period have elapsed, and a queued next ratio.
  int ratio  [NUM_CH];
  int elapsed[NUM_CH];
  int queued [NUM_CH];
  bit waiting[NUM_CH];

  function automatic void model_reset();
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ratio[i] = int'(RESET_DIV); elapsed[i] = 0; queued[i] = 0; waiting[i] = 0;
    end
  endfunction

  task automatic check(input string name, input logic [NUM_CH-1:0] got,
                       input logic [NUM_CH-1:0] want, input string tag);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s [%s] t=%0t: got %b, required %b", name, tag, $time, got, want);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("div_out",     div_out,     e.out,  e.tag);
        check("div_tick",    div_tick,    e.tick, e.tag);
        check("cfg_pending", cfg_pending, e.pend, e.tag);
        check("cfg_ready",   NUM_CH'(cfg_ready), NUM_CH'(e.ready), e.tag);
      end
    end
  end

  // One clock of stimulus; expectation derived from the model, then the model advances
  task automatic step(input logic en, input logic v, input logic [1:0] ch,
                      input logic [CNT_W-1:0] dv, input string tag, output bit acc);
    exp_t e;
    bit   done;
    @(negedge clk);
    reset = 1'b0; enable = en; cfg_valid = v; cfg_ch = ch; cfg_div = dv;
    #1;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      e.out[i]  = (ratio[i] >= 1) && (elapsed[i] < (ratio[i] + 1) / 2);
      e.tick[i] = en && (ratio[i] >= 1) && (elapsed[i] == ratio[i] - 1);
      e.pend[i] = waiting[i];
    end
    e.ready = (int'(ch) >= int'(NUM_CH)) || !waiting[ch];
    e.tag   = tag;
    q.push_back(e);
    acc = v && e.ready;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      done = e.tick[i];
      if (waiting[i] && (done || ratio[i] == 0)) begin
        ratio[i] = queued[i]; elapsed[i] = 0; waiting[i] = 0;
      end else if (ratio[i] == 0) begin
        elapsed[i] = 0;
      end else if (en) begin
        elapsed[i] = done ? 0 : elapsed[i] + 1;
      end
    end
    if (acc && int'(ch) < int'(NUM_CH)) begin
      queued[ch] = int'(dv); waiting[ch] = 1;
    end
  endtask

  task automatic run(input int n, input logic en, input string tag);
    bit a;
    for (int k = 0; k < n; k++) step(en, 1'b0, 2'd0, '0, tag, a);
  endtask

  task automatic cfg(input logic [1:0] ch, input int dv, input string tag);
    bit a;
    step(1'b1, 1'b1, ch, CNT_W'(dv), tag, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  initial begin
    bit a;
    int waited;
    reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    do_reset();

    // Reset values, independent of the model
    #1;
    check("reset_cfg_pending", cfg_pending, '0, "reset");
    check("reset_div_out",     div_out,     '1, "reset");
    check("reset_cfg_ready",   NUM_CH'(cfg_ready), NUM_CH'(1), "reset");

    run(10, 1'b1, "defaults");
    cfg(2'd0, 5, "ch0_r5");
    run(20, 1'b1, "ch0_r5");
    cfg(2'd1, 0, "ch1_r0");
    run(8, 1'b1, "ch1_off");
    cfg(2'd1, 4, "ch1_r4");
    run(12, 1'b1, "ch1_r4");

    // Back-to-back updates to ch0: the second waits for a wrap
    cfg(2'd0, 200, "ch0_r200");
    waited = 0;
    do begin
      step(1'b1, 1'b1, 2'd0, CNT_W'(3), "ch0_second", a);
      waited++;
    end while (!a && waited < 400);
    n_chk++;
    if (a) n_pass++;
    else $display("FAIL ch0_second_accept: not accepted after %0d cycles, required accept", waited);
    run(20, 1'b1, "ch0_r3");

    // Freeze mid-period on R=7
    cfg(2'd2, 7, "ch2_r7");
    run(12, 1'b1, "ch2_r7");
    run(10, 1'b0, "freeze");
    run(12, 1'b1, "resume");

    // Out-of-range channel is always ready and has no effect
    cfg(2'd3, 9, "ch_oob");
    run(6, 1'b1, "ch_oob");

    // Randomised traffic
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 12)), "random", a);
    end

    // Reset while an update is pending discards it
    cfg(2'd0, 50, "pre_reset");
    cfg(2'd1, 60, "pre_reset");
    do_reset();
    run(8, 1'b1, "post_reset");
    run(4, 1'b0, "post_reset_off");

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
